// File: rtl/mips_datapath_register_scoreboard_if.sv
// Port bundle between decode and the register scoreboard: issue request, source/destination
// addresses, writeback retire, flush and the hazard status returned to decode.
interface mips_datapath_register_scoreboard_if #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int LAT_W    = 3
);
  logic                issue_valid;
  logic                issue_ready;
  logic [ADDR_W-1:0]   rd1_addr;
  logic                rd1_use;
  logic [ADDR_W-1:0]   rd2_addr;
  logic                rd2_use;
  logic [ADDR_W-1:0]   wr_addr;
  logic                wr_en;
  logic [LAT_W-1:0]    wr_latency;
  logic                wb_valid;
  logic [ADDR_W-1:0]   wb_addr;
  logic                flush;
  logic [1:0]          stall_src;
  logic                stall_waw;
  logic [NUM_REGS-1:0] busy_mask;
  logic                error;

  modport master (
    output issue_valid, rd1_addr, rd1_use, rd2_addr, rd2_use,
           wr_addr, wr_en, wr_latency, wb_valid, wb_addr, flush,
    input  issue_ready, stall_src, stall_waw, busy_mask, error
  );

  modport slave (
    input  issue_valid, rd1_addr, rd1_use, rd2_addr, rd2_use,
           wr_addr, wr_en, wr_latency, wb_valid, wb_addr, flush,
    output issue_ready, stall_src, stall_waw, busy_mask, error
  );
endinterface

// File: rtl/mips_datapath_register_scoreboard.sv
// Issue-side register scoreboard: per-register pending-write counters and forwarding timers
// gate decode on RAW, WAW-reordering and counter-saturation hazards.
module mips_datapath_register_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int CNT_W    = 2,
  parameter int LAT_W    = 3
) (
  input  logic clock,
  input  logic reset_n,
  mips_datapath_register_scoreboard_if.slave sb
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0]    cnt_q [NUM_REGS];
  logic [CNT_W-1:0]    cnt_d [NUM_REGS];
  logic [LAT_W-1:0]    tmr_q [NUM_REGS];
  logic [LAT_W-1:0]    tmr_d [NUM_REGS];
  logic                error_q;
  logic                error_d;

  logic [1:0]          stall_src;
  logic                stall_waw;
  logic                issue_ready;
  logic                fire;
  logic [NUM_REGS-1:0] busy_mask;

  function automatic logic cnt_saturated(input logic [CNT_W-1:0] c);
    return c == CNT_MAX;
  endfunction

  // An underflowing retire holds the count at zero; the caller raises error.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                input logic inc,
                                                input logic dec);
    logic [CNT_W-1:0] n;
    n = c;
    if (inc && !dec)
      n = c + CNT_W'(1);
    else if (dec && !inc && c != '0)
      n = c - CNT_W'(1);
    return n;
  endfunction

  function automatic logic [LAT_W-1:0] tmr_next(input logic [LAT_W-1:0] t,
                                                input logic load,
                                                input logic [LAT_W-1:0] lat);
    logic [LAT_W-1:0] n;
    n = t;
    if (load)
      n = lat;
    else if (t != '0)
      n = t - LAT_W'(1);
    return n;
  endfunction

  // Hazard detection: purely combinational from registered state and the presented instruction
  always_comb begin
    stall_src   = 2'b00;
    stall_waw   = 1'b0;
    if (sb.rd1_use && sb.rd1_addr != '0 && tmr_q[sb.rd1_addr] != '0)
      stall_src[0] = 1'b1;
    if (sb.rd2_use && sb.rd2_addr != '0 && tmr_q[sb.rd2_addr] != '0)
      stall_src[1] = 1'b1;
    if (sb.wr_en && sb.wr_addr != '0 &&
        (tmr_q[sb.wr_addr] > sb.wr_latency || cnt_saturated(cnt_q[sb.wr_addr])))
      stall_waw = 1'b1;
    issue_ready = ~(|stall_src | stall_waw);
    fire        = sb.issue_valid & issue_ready & ~sb.flush;
  end

  always_comb begin
    busy_mask = '0;
    for (int r = 1; r < NUM_REGS; r++)
      busy_mask[r] = |cnt_q[r];
  end

  // Next state: flush wipes everything and drops concurrent issue/retire
  always_comb begin
    logic inc;
    logic dec;
    inc     = 1'b0;
    dec     = 1'b0;
    error_d = error_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = '0;
      tmr_d[r] = '0;
    end
    if (!sb.flush) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        inc      = fire & sb.wr_en & (sb.wr_addr == ADDR_W'(r));
        dec      = sb.wb_valid & (sb.wb_addr == ADDR_W'(r));
        cnt_d[r] = cnt_next(cnt_q[r], inc, dec);
        tmr_d[r] = tmr_next(tmr_q[r], inc, sb.wr_latency);
        if (dec && !inc && cnt_q[r] == '0)
          error_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
        tmr_q[r] <= '0;
      end
      error_q <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
        tmr_q[r] <= tmr_d[r];
      end
      error_q <= error_d;
    end
  end

  assign sb.issue_ready = issue_ready;
  assign sb.stall_src   = stall_src;
  assign sb.stall_waw   = stall_waw;
  assign sb.busy_mask   = busy_mask;
  assign sb.error       = error_q;

endmodule

// File: tb/tb_mips_datapath_register_scoreboard.sv
// Bench for the register scoreboard: directed hazard scenarios plus random traffic, all
// checked against an integer-array model of pending counts and forwarding timers.
module tb_mips_datapath_register_scoreboard;

  localparam int NR   = 32;
  localparam int CMAX = 3;

  logic clock;
  logic reset_n;

  mips_datapath_register_scoreboard_if #(.NUM_REGS(NR), .ADDR_W(5), .LAT_W(3)) sbi ();

  mips_datapath_register_scoreboard #(.NUM_REGS(NR), .ADDR_W(5), .CNT_W(2), .LAT_W(3)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .sb     (sbi)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks;
  int n_fail;

  int m_cnt [NR];
  int m_tmr [NR];
  bit m_err;

  logic [1:0]    e_src;
  logic          e_waw;
  logic          e_ready;
  logic [NR-1:0] e_busy;

  logic [1:0]    d_src;
  logic          d_waw;
  logic          d_ready;
  logic [NR-1:0] d_busy;
  logic          d_err;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      m_cnt[r] = 0;
      m_tmr[r] = 0;
    end
    m_err = 1'b0;
  endtask

  task automatic model_eval();
    int wa;
    e_src = 2'b00;
    if (sbi.rd1_use && sbi.rd1_addr != 0 && m_tmr[sbi.rd1_addr] != 0) e_src[0] = 1'b1;
    if (sbi.rd2_use && sbi.rd2_addr != 0 && m_tmr[sbi.rd2_addr] != 0) e_src[1] = 1'b1;
    wa    = int'(sbi.wr_addr);
    e_waw = sbi.wr_en && wa != 0 &&
            (m_tmr[wa] > int'(sbi.wr_latency) || m_cnt[wa] == CMAX);
    e_ready = (e_src == 2'b00) && !e_waw;
    e_busy = '0;
    for (int r = 1; r < NR; r++)
      if (m_cnt[r] > 0) e_busy[r] = 1'b1;
  endtask

  task automatic model_commit();
    bit fire;
    bit inc;
    bit dec;
    if (sbi.flush) begin
      for (int r = 0; r < NR; r++) begin
        m_cnt[r] = 0;
        m_tmr[r] = 0;
      end
      return;
    end
    fire = sbi.issue_valid && e_ready;
    for (int r = 1; r < NR; r++) begin
      inc = fire && sbi.wr_en && int'(sbi.wr_addr) == r;
      dec = sbi.wb_valid && int'(sbi.wb_addr) == r;
      if (inc) m_tmr[r] = int'(sbi.wr_latency);
      else if (m_tmr[r] > 0) m_tmr[r] = m_tmr[r] - 1;
      if (inc && !dec) m_cnt[r] = m_cnt[r] + 1;
      else if (dec && !inc) begin
        if (m_cnt[r] == 0) m_err = 1'b1;
        else m_cnt[r] = m_cnt[r] - 1;
      end
    end
  endtask

  task automatic drive(input bit v, input int a1, input bit u1, input int a2, input bit u2,
                       input int wa, input bit we, input int lat,
                       input bit wbv, input int wba, input bit fl);
    sbi.issue_valid = v;
    sbi.rd1_addr    = 5'(a1);
    sbi.rd1_use     = u1;
    sbi.rd2_addr    = 5'(a2);
    sbi.rd2_use     = u2;
    sbi.wr_addr     = 5'(wa);
    sbi.wr_en       = we;
    sbi.wr_latency  = 3'(lat);
    sbi.wb_valid    = wbv;
    sbi.wb_addr     = 5'(wba);
    sbi.flush       = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic retire(input int r);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, r, 0);
  endtask

  // Called at a falling edge with inputs applied; returns at the next falling edge.
  task automatic step();
    #1;
    model_eval();
    d_src   = sbi.stall_src;
    d_waw   = sbi.stall_waw;
    d_ready = sbi.issue_ready;
    d_busy  = sbi.busy_mask;
    d_err   = sbi.error;
    chk_eq("stall_src",   d_src,   e_src);
    chk_eq("stall_waw",   d_waw,   e_waw);
    chk_eq("issue_ready", d_ready, e_ready);
    chk_eq("busy_mask",   d_busy,  e_busy);
    chk_eq("error",       d_err,   m_err);
    @(posedge clock);
    model_commit();
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    idle();
    model_reset();
    #2;
    chk_eq("rst_busy",  sbi.busy_mask,   0);
    chk_eq("rst_ready", sbi.issue_ready, 1);
    chk_eq("rst_stall", {sbi.stall_src, sbi.stall_waw}, 0);
    chk_eq("rst_error", sbi.error,       0);
    @(negedge clock);
    reset_n = 1'b1;

    // Load-use: one stall cycle, then the dependent add fires
    drive(1, 0, 0, 0, 0, 8, 1, 1, 0, 0, 0); step();
    chk_eq("lu_lw_ready", d_ready, 1);
    drive(1, 8, 1, 0, 0, 10, 1, 0, 0, 0, 0); step();
    chk_eq("lu_stall_src", d_src, 2'b01);
    chk_eq("lu_ready0", d_ready, 0);
    step();
    chk_eq("lu_ready1", d_ready, 1);
    retire(8); step();
    retire(10); step();

    // ALU back-to-back
    drive(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0); step();
    drive(1, 0, 0, 9, 1, 11, 1, 0, 0, 0, 0); step();
    chk_eq("alu_ready", d_ready, 1);
    chk_eq("alu_busy9", d_busy[9], 1);
    idle(); step();
    chk_eq("alu_busy9_hold", d_busy[9], 1);
    retire(9); step();
    idle(); step();
    chk_eq("alu_busy9_clr", d_busy[9], 0);
    retire(11); step();

    // WAW: L=3 then L=0 to the same register stalls three cycles
    drive(1, 0, 0, 0, 0, 5, 1, 3, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (d_ready) break;
      n++;
    end
    chk_eq("waw_stall_cycles", n, 3);
    retire(5); step();
    retire(5); step();

    // Saturation: fourth outstanding write to $5 is held
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0); step();
      chk_eq("sat_fill_ready", d_ready, 1);
    end
    step();
    chk_eq("sat_waw", d_waw, 1);
    chk_eq("sat_ready", d_ready, 0);
    drive(1, 0, 0, 0, 0, 5, 1, 0, 1, 5, 0); step();
    chk_eq("sat_still_held", d_waw, 1);
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0); step();
    chk_eq("sat_release", d_ready, 1);
    for (int i = 0; i < 3; i++) begin retire(5); step(); end

    // Simultaneous issue and retire on $3
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0, 3, 1, 0, 1, 3, 0); step();
    idle(); step();
    chk_eq("iss_ret_busy3", d_busy[3], 1);
    retire(3); step();
    idle(); step();
    chk_eq("iss_ret_busy3_clr", d_busy[3], 0);
    chk_eq("iss_ret_noerr", d_err, 0);

    // $0 is never tracked
    drive(1, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0); step();
    drive(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0); step();
    chk_eq("r0_ready", d_ready, 1);
    chk_eq("r0_busy", d_busy, 0);

    // Underflow, sticky error; retiring $0 is ignored
    retire(0); step();
    chk_eq("r0_retire_noerr", d_err, 0);
    retire(4); step();
    idle(); step();
    chk_eq("uf_error", d_err, 1);
    idle(); step();
    chk_eq("uf_sticky", d_err, 1);

    // Flush with three pending writes; concurrent issue and retire are dropped
    for (int i = 12; i < 15; i++) begin
      drive(1, 0, 0, 0, 0, i, 1, 2, 0, 0, 0); step();
    end
    idle(); step();
    chk_eq("flush_pre_busy", d_busy, 32'h0000_7000);
    drive(1, 0, 0, 0, 0, 15, 1, 2, 1, 12, 1); step();
    idle(); step();
    chk_eq("flush_busy", d_busy, 0);
    chk_eq("flush_err_kept", d_err, 1);
    chk_eq("flush_ready", d_ready, 1);

    // Reset mid-run takes effect between clock edges
    drive(1, 0, 0, 0, 0, 20, 1, 5, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0, 21, 1, 0, 0, 0, 0); step();
    drive(1, 20, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk_eq("prerst_ready", sbi.issue_ready, 0);
    chk_eq("prerst_busy", sbi.busy_mask, 32'h0030_0000);
    #1 reset_n = 1'b0;
    #1;
    chk_eq("midrst_busy",  sbi.busy_mask,   0);
    chk_eq("midrst_error", sbi.error,       0);
    chk_eq("midrst_ready", sbi.issue_ready, 1);
    chk_eq("midrst_stall", {sbi.stall_src, sbi.stall_waw}, 0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    idle();

    // Random traffic on a small register window to provoke hazards
    for (int c = 0; c < 600; c++) begin
      int lat;
      lat = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
      drive($urandom_range(0, 9) < 7,
            $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 3) != 0, lat,
            $urandom_range(0, 9) < 4, $urandom_range(0, 7),
            $urandom_range(0, 49) == 0);
      step();
    end
    idle(); step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
